// File: rtl/hd44780_ctrl_pkg.sv
// Shared types and constants for the HD44780 4-bit sequencer: state encoding,
// delay-select codes and the fixed power-on init script.
package hd44780_ctrl_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        ISSUE,
        ACCEPT,
        DRAIN,
        DELAY,
        IDLE
    } state_t;

    typedef enum logic [1:0] {
        D53,
        D100,
        D4P1,
        D3M
    } dly_sel_t;

    localparam int INIT_LEN = 6;

    typedef struct packed {
        logic [7:0] data;
        dly_sel_t   dly;
    } init_entry_t;

    function automatic init_entry_t init_rom(input logic [2:0] idx);
        init_entry_t e;
        case (idx)
            3'd0:    e = '{data: 8'h33, dly: D4P1};
            3'd1:    e = '{data: 8'h32, dly: D100};
            3'd2:    e = '{data: 8'h28, dly: D53};
            3'd3:    e = '{data: 8'h0C, dly: D53};
            3'd4:    e = '{data: 8'h01, dly: D3M};
            default: e = '{data: 8'h06, dly: D53};
        endcase
        return e;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution delay.
    function automatic dly_sel_t client_dly(input logic rs, input logic [7:0] data);
        if (!rs && data[7:1] == 7'b0000000 && data[0])
            return D3M;
        if (!rs && data[7:1] == 7'b0000001)
            return D3M;
        return D53;
    endfunction

endpackage

// File: rtl/hd44780_delay_timer.sv
// Loadable down-counter; done marks the last cycle of a loaded delay so that a
// delay of N spends exactly N cycles waiting (N=0 finishes in one cycle).
module hd44780_delay_timer #(
    parameter int                    TIMER_BITS  = 23,
    parameter logic [TIMER_BITS-1:0] RESET_VALUE = '0
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  load,
    input  logic [TIMER_BITS-1:0] load_value,
    output logic                  done
);

    logic [TIMER_BITS-1:0] count;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)
            count <= RESET_VALUE;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count == '0) || (count == TIMER_BITS'(1));

endmodule

// File: rtl/hd44780_controller.sv
// Top-level HD44780 sequencer: runs the power-on init script, then forwards
// single client bytes to the bytesender and enforces execution delays.
//
// state  | meaning
// PWRUP  | waiting out the power-up delay after reset
// ISSUE  | waiting for bytesender idle, then strobing the current byte
// ACCEPT | holding byte stable until bytesender reports busy
// DRAIN  | waiting for both nybbles to finish, then loading the delay
// DELAY  | waiting out the instruction execution delay
// IDLE   | ready for a client request
module hd44780_controller
    import hd44780_ctrl_pkg::*;
#(
    parameter int DLY_PWRUP  = 4800000,
    parameter int DLY_4P1MS  = 196800,
    parameter int DLY_100US  = 4800,
    parameter int DLY_3MS    = 144000,
    parameter int DLY_53US   = 2544,
    parameter int TIMER_BITS = 23
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_ready,
    output logic       o_bs_stb,
    output logic       o_bs_rs,
    output logic [7:0] o_bs_data,
    input  logic       i_bs_busy
);

    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic        req_rs, req_rs_nxt;
    logic [7:0]  req_data, req_data_nxt;
    logic        busy_q, busy_nxt;
    logic        ready_q, ready_nxt;
    logic        stb_q, stb_nxt;
    logic        rs_q, rs_nxt;
    logic [7:0]  data_q, data_nxt;

    logic                  tmr_load;
    logic [TIMER_BITS-1:0] tmr_value;
    logic                  tmr_done;
    init_entry_t           rom;
    dly_sel_t              dly_sel;
    logic [7:0]            src_data;
    logic                  src_rs;

    hd44780_delay_timer #(
        .TIMER_BITS  (TIMER_BITS),
        .RESET_VALUE (TIMER_BITS'(DLY_PWRUP))
    ) u_timer (
        .CLK_I      (CLK_I),
        .RST_I      (RST_I),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    // Source of the byte in flight: init ROM until ready, request latch after.
    always_comb begin
        rom      = init_rom(idx);
        src_data = ready_q ? req_data : rom.data;
        src_rs   = ready_q ? req_rs : 1'b0;
        dly_sel  = ready_q ? client_dly(req_rs, req_data) : rom.dly;
        case (dly_sel)
            D4P1:    tmr_value = TIMER_BITS'(DLY_4P1MS);
            D100:    tmr_value = TIMER_BITS'(DLY_100US);
            D3M:     tmr_value = TIMER_BITS'(DLY_3MS);
            default: tmr_value = TIMER_BITS'(DLY_53US);
        endcase
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        req_rs_nxt   = req_rs;
        req_data_nxt = req_data;
        ready_nxt    = ready_q;
        stb_nxt      = 1'b0;
        rs_nxt       = rs_q;
        data_nxt     = data_q;
        tmr_load     = 1'b0;

        case (state)
            PWRUP: begin
                if (tmr_done)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!i_bs_busy) begin
                    stb_nxt   = 1'b1;
                    data_nxt  = src_data;
                    rs_nxt    = src_rs;
                    state_nxt = ACCEPT;
                end
            end
            ACCEPT: begin
                if (i_bs_busy)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!i_bs_busy) begin
                    tmr_load  = 1'b1;
                    state_nxt = DELAY;
                end
            end
            DELAY: begin
                if (tmr_done) begin
                    if (ready_q) begin
                        state_nxt = IDLE;
                    end else if (idx == 3'(INIT_LEN - 1)) begin
                        ready_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = ISSUE;
                    end
                end
            end
            IDLE: begin
                if (STB_I) begin
                    req_rs_nxt   = i_rs;
                    req_data_nxt = i_data;
                    state_nxt    = ISSUE;
                end
            end
            default: state_nxt = PWRUP;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state    <= PWRUP;
            idx      <= 3'd0;
            req_rs   <= 1'b0;
            req_data <= 8'h00;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            stb_q    <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            req_rs   <= req_rs_nxt;
            req_data <= req_data_nxt;
            busy_q   <= busy_nxt;
            ready_q  <= ready_nxt;
            stb_q    <= stb_nxt;
            rs_q     <= rs_nxt;
            data_q   <= data_nxt;
        end
    end

    assign o_busy    = busy_q;
    assign o_ready   = ready_q;
    assign o_bs_stb  = stb_q;
    assign o_bs_rs   = rs_q;
    assign o_bs_data = data_q;

endmodule
